// File: rtl/mux_pkg.sv
// Shared types and index helpers for the N:1 channel selector.
package mux_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index width for a channel count; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Advance a channel index, wrapping at channels-1 (works for non-power-of-2 counts).
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned channels);
        return (idx == channels - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_nx1_comb.sv
// Combinational N:1 selector over a flattened bus; out-of-range index yields channel 0.
module mux_nx1_comb
    import mux_pkg::*;
#(
    parameter int unsigned BITS     = 16,
    parameter int unsigned CHANNELS = 128,
    parameter int unsigned SEL_BITS = idx_width(CHANNELS)
) (
    input  logic [CHANNELS*BITS-1:0] bus,
    input  logic [SEL_BITS-1:0]      sel,
    output logic [BITS-1:0]          data_c,
    output logic                     err_c
);

    int unsigned pick;

    // Substitute channel 0 for any index past the last channel.
    always_comb begin
        err_c  = (32'(sel) >= CHANNELS);
        pick   = err_c ? 0 : 32'(sel);
        data_c = bus[pick*BITS +: BITS];
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N:1 channel selector with direct (handshaked) and snapshot-scan modes.
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter int unsigned BITS     = 16,
    parameter int unsigned CHANNELS = 128,
    parameter int unsigned SEL_BITS = idx_width(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS*BITS-1:0] mux_inputs,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_BITS-1:0]      sel_input,
    input  logic                     start,
    input  logic [SEL_BITS-1:0]      scan_first,
    input  logic [SEL_BITS-1:0]      scan_last,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITS-1:0]          mux_output,
    output logic                     out_last,
    output logic                     sel_err
);

    localparam int unsigned          BUS_W    = CHANNELS * BITS;
    localparam logic [SEL_BITS-1:0]  LAST_IDX = SEL_BITS'(CHANNELS - 1);

    state_t              state, state_d;
    logic [SEL_BITS-1:0] idx, idx_d;
    logic [SEL_BITS-1:0] last_r, last_d;
    logic [BUS_W-1:0]    snapshot;
    logic                snap_load_c;
    logic                slot_free_c;
    logic                out_valid_d, out_last_d, sel_err_d;
    logic [BITS-1:0]     mux_output_d;
    logic [BITS-1:0]     live_data_c, snap_data_c;
    logic                live_err_c, snap_err_c;
    logic                first_bad_c, last_bad_c;

    mux_nx1_comb #(.BITS(BITS), .CHANNELS(CHANNELS), .SEL_BITS(SEL_BITS)) u_live_mux (
        .bus    (mux_inputs),
        .sel    (sel_input),
        .data_c (live_data_c),
        .err_c  (live_err_c)
    );

    mux_nx1_comb #(.BITS(BITS), .CHANNELS(CHANNELS), .SEL_BITS(SEL_BITS)) u_snap_mux (
        .bus    (snapshot),
        .sel    (idx),
        .data_c (snap_data_c),
        .err_c  (snap_err_c)
    );

    assign slot_free_c = !out_valid || out_ready;
    assign in_ready    = (state == IDLE) && !mode && slot_free_c;
    assign busy        = (state == SCAN);
    assign first_bad_c = (32'(scan_first) >= CHANNELS);
    assign last_bad_c  = (32'(scan_last) >= CHANNELS);

    // Next-state and output-register next values.
    always_comb begin
        state_d      = state;
        idx_d        = idx;
        last_d       = last_r;
        snap_load_c  = 1'b0;
        out_valid_d  = out_valid && !out_ready;
        mux_output_d = mux_output;
        out_last_d   = out_last;
        sel_err_d    = 1'b0;
        case (state)
            IDLE: begin
                if (mode) begin
                    if (start) begin
                        snap_load_c = 1'b1;
                        idx_d       = first_bad_c ? '0 : scan_first;
                        last_d      = last_bad_c ? LAST_IDX : scan_last;
                        sel_err_d   = first_bad_c || last_bad_c;
                        state_d     = SCAN;
                    end
                end else if (in_valid && slot_free_c) begin
                    mux_output_d = live_data_c;
                    out_valid_d  = 1'b1;
                    out_last_d   = 1'b0;
                    sel_err_d    = live_err_c;
                end
            end
            SCAN: begin
                if (slot_free_c) begin
                    mux_output_d = snap_data_c;
                    out_valid_d  = 1'b1;
                    out_last_d   = (idx == last_r);
                    sel_err_d    = snap_err_c;
                    idx_d        = SEL_BITS'(next_idx(32'(idx), CHANNELS));
                    if (idx == last_r) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, scan indices and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            last_r     <= '0;
            out_valid  <= 1'b0;
            mux_output <= '0;
            out_last   <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            last_r     <= last_d;
            out_valid  <= out_valid_d;
            mux_output <= mux_output_d;
            out_last   <= out_last_d;
            sel_err    <= sel_err_d;
        end
    end

    // Whole-bus snapshot taken when a scan starts; contents are don't-care otherwise.
    always_ff @(posedge clk) begin
        if (snap_load_c) begin
            snapshot <= mux_inputs;
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1 at 128 and 100 channels.
module tb_mux_scan_nx1;

    localparam int unsigned BITS = 16;
    localparam int unsigned SB   = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic [128*16-1:0] bus128;
    logic [100*16-1:0] bus100;
    logic            mode, in_valid, out_ready, start128, start100;
    logic [SB-1:0]   sel, first, last;

    logic            rdy128, busy128, v128, l128, e128;
    logic [15:0]     d128;
    logic            rdy100, busy100, v100, l100, e100;
    logic [15:0]     d100;

    int total = 0;
    int bad   = 0;

    mux_scan_nx1 #(.BITS(BITS), .CHANNELS(128)) u_dut128 (
        .clk(clk), .rst(rst), .mux_inputs(bus128), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy128), .sel_input(sel),
        .start(start128), .scan_first(first), .scan_last(last),
        .busy(busy128), .out_valid(v128), .out_ready(out_ready),
        .mux_output(d128), .out_last(l128), .sel_err(e128)
    );

    mux_scan_nx1 #(.BITS(BITS), .CHANNELS(100)) u_dut100 (
        .clk(clk), .rst(rst), .mux_inputs(bus100), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy100), .sel_input(sel),
        .start(start100), .scan_first(first), .scan_last(last),
        .busy(busy100), .out_valid(v100), .out_ready(out_ready),
        .mux_output(d100), .out_last(l100), .sel_err(e100)
    );

    always #5 clk = ~clk;

    function automatic logic [128*16-1:0] fill128(input logic [15:0] base);
        logic [128*16-1:0] v;
        for (int k = 0; k < 128; k++) v[k*16 +: 16] = base + 16'(k);
        return v;
    endfunction

    function automatic logic [100*16-1:0] fill100(input logic [15:0] base);
        logic [100*16-1:0] v;
        for (int k = 0; k < 100; k++) v[k*16 +: 16] = base + 16'(k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        start128 = 1'b0; start100 = 1'b0; sel = '0; first = '0; last = '0;
        bus128 = fill128(16'h0100);
        bus100 = fill100(16'h0200);
        step();
        step();
        chk("rst_valid", 32'(v128), 32'd0);
        chk("rst_data", 32'(d128), 32'd0);
        chk("rst_busy", 32'(busy128), 32'd0);
        chk("rst_last", 32'(l128), 32'd0);
        chk("rst_err", 32'(e128), 32'd0);

        // Direct mode, back-to-back requests
        rst = 1'b0; mode = 1'b0; in_valid = 1'b1; sel = 7'd0;
        #1 chk("dir_in_ready", 32'(rdy128), 32'd1);
        step();
        chk("dir0_valid", 32'(v128), 32'd1);
        chk("dir0_data", 32'(d128), 32'h100);
        chk("dir0_last", 32'(l128), 32'd0);
        sel = 7'd1;
        step();
        chk("dir1_data", 32'(d128), 32'h101);
        sel = 7'd127;
        step();
        chk("dir127_data", 32'(d128), 32'h17F);
        chk("dir127_err", 32'(e128), 32'd0);
        in_valid = 1'b0;
        step();
        chk("dir_drain", 32'(v128), 32'd0);

        // Direct backpressure
        in_valid = 1'b1; sel = 7'd5;
        step();
        chk("bp_first", 32'(d128), 32'h105);
        out_ready = 1'b0; sel = 7'd6;
        #1 chk("bp_ready_low", 32'(rdy128), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", 32'(v128), 32'd1);
            chk("bp_hold_data", 32'(d128), 32'h105);
        end
        out_ready = 1'b1;
        #1 chk("bp_ready_high", 32'(rdy128), 32'd1);
        step();
        chk("bp_next", 32'(d128), 32'h106);
        in_valid = 1'b0;
        step();
        chk("bp_drain", 32'(v128), 32'd0);

        // Wrapping scan 126..1 with live bus churn; start beats in_valid
        mode = 1'b1; start128 = 1'b1; first = 7'd126; last = 7'd1; in_valid = 1'b1;
        #1 chk("scan_in_ready", 32'(rdy128), 32'd0);
        step();
        chk("scan_busy", 32'(busy128), 32'd1);
        chk("scan_no_direct", 32'(v128), 32'd0);
        start128 = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] expd [4];
            expd[0] = 16'h17E; expd[1] = 16'h17F; expd[2] = 16'h100; expd[3] = 16'h101;
            bus128 = fill128(16'h0900 + 16'(i * 16'h10));
            step();
            chk("wrap_valid", 32'(v128), 32'd1);
            chk("wrap_data", 32'(d128), 32'(expd[i]));
            chk("wrap_last", 32'(l128), (i == 3) ? 32'd1 : 32'd0);
            chk("wrap_busy", 32'(busy128), (i < 3) ? 32'd1 : 32'd0);
        end
        step();
        chk("wrap_end_valid", 32'(v128), 32'd0);
        chk("wrap_end_busy", 32'(busy128), 32'd0);
        bus128 = fill128(16'h0100);

        // CHANNELS=100: out-of-range direct index
        mode = 1'b0; in_valid = 1'b1; sel = 7'd105;
        step();
        chk("c100_oor_valid", 32'(v100), 32'd1);
        chk("c100_oor_data", 32'(d100), 32'h200);
        chk("c100_oor_err", 32'(e100), 32'd1);
        in_valid = 1'b0;
        step();
        chk("c100_err_pulse", 32'(e100), 32'd0);
        chk("c100_drain", 32'(v100), 32'd0);

        // CHANNELS=100: scan_last clamped to 99
        mode = 1'b1; start100 = 1'b1; first = 7'd97; last = 7'd120;
        step();
        chk("c100_scan_busy", 32'(busy100), 32'd1);
        chk("c100_scan_err", 32'(e100), 32'd1);
        start100 = 1'b0;
        step();
        chk("c100_b0", 32'(d100), 32'h261);
        chk("c100_b0_last", 32'(l100), 32'd0);
        chk("c100_b0_err", 32'(e100), 32'd0);
        step();
        chk("c100_b1", 32'(d100), 32'h262);
        step();
        chk("c100_b2", 32'(d100), 32'h263);
        chk("c100_b2_last", 32'(l100), 32'd1);
        chk("c100_b2_busy", 32'(busy100), 32'd0);
        step();
        chk("c100_end", 32'(v100), 32'd0);

        // Reset during a 10-beat scan, then a fresh full scan
        first = 7'd10; last = 7'd19; start128 = 1'b1;
        step();
        start128 = 1'b0;
        step();
        chk("rs_b0", 32'(d128), 32'h10A);
        step();
        chk("rs_b1", 32'(d128), 32'h10B);
        out_ready = 1'b0; rst = 1'b1;
        step();
        chk("rs_valid", 32'(v128), 32'd0);
        chk("rs_busy", 32'(busy128), 32'd0);
        chk("rs_data", 32'(d128), 32'd0);
        rst = 1'b0; out_ready = 1'b1; start128 = 1'b1;
        step();
        chk("rs_restart_busy", 32'(busy128), 32'd1);
        chk("rs_restart_idle_out", 32'(v128), 32'd0);
        start128 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rs_fresh_data", 32'(d128), 32'h10A + 32'(i));
            chk("rs_fresh_last", 32'(l128), (i == 9) ? 32'd1 : 32'd0);
        end
        chk("rs_fresh_busy", 32'(busy128), 32'd0);
        step();
        chk("rs_fresh_end", 32'(v128), 32'd0);

        // start ignored with mode=0, and while busy
        mode = 1'b0; start128 = 1'b1;
        step();
        chk("ign_m0_busy", 32'(busy128), 32'd0);
        chk("ign_m0_valid", 32'(v128), 32'd0);
        mode = 1'b1; first = 7'd3; last = 7'd4;
        step();
        chk("ign_scan_busy", 32'(busy128), 32'd1);
        first = 7'd50; last = 7'd60; in_valid = 1'b1;
        step();
        chk("ign_b0", 32'(d128), 32'h103);
        start128 = 1'b0; in_valid = 1'b0;
        step();
        chk("ign_b1", 32'(d128), 32'h104);
        chk("ign_b1_last", 32'(l128), 32'd1);
        chk("ign_b1_busy", 32'(busy128), 32'd0);
        step();
        chk("ign_end0", 32'(v128), 32'd0);
        step();
        chk("ign_end1", 32'(v128), 32'd0);
        chk("ign_end_busy", 32'(busy128), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
